// File: rtl/befehl_holen.sv
// ---------------------------------------------------------------------------
// befehl_holen - instruction fetch stage
//
// Keeps the program counter, issues single-cycle read requests to the
// word-addressed RAM, captures the returned word and hands it to decode over
// a valid/ready handshake. Execute can redirect the PC at any time after the
// START cycle; a redirect discards whatever read is still in flight.
//
// Ports
//   Clock          single clock, all state on the rising edge
//   Reset_n        synchronous, active-low reset
//   SpeicherFrei   arbiter grants the RAM port to fetch this cycle
//   LesenAn        RAM read strobe (HOLEN and granted)
//   Adresse        RAM word address, always the PC
//   DatenRaus      RAM read data
//   DatenBereit    RAM read-done pulse, one cycle after LesenAn
//   Holt           fetch owns the RAM port (HOLEN or WARTEN)
//   Befehl         captured instruction
//   BefehlsZaehler address Befehl was fetched from
//   BefehlGueltig  Befehl/BefehlsZaehler valid for decode
//   BefehlBereit   decode accepts the presented instruction
//   SprungAn       redirect request from execute
//   SprungZiel     absolute redirect target
// ---------------------------------------------------------------------------
module befehl_holen #(
    parameter int WORDSIZE      = 32,
    parameter int WORDS         = 32,
    parameter int START_ADRESSE = 0,
    localparam int AW           = $clog2(WORDS)
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                SpeicherFrei,
    output logic                LesenAn,
    output logic [AW-1:0]       Adresse,
    input  logic [WORDSIZE-1:0] DatenRaus,
    input  logic                DatenBereit,
    output logic                Holt,
    output logic [WORDSIZE-1:0] Befehl,
    output logic [AW-1:0]       BefehlsZaehler,
    output logic                BefehlGueltig,
    input  logic                BefehlBereit,
    input  logic                SprungAn,
    input  logic [AW-1:0]       SprungZiel
);

    typedef enum logic [1:0] {
        START,
        HOLEN,
        WARTEN,
        VOLL
    } zustandT;

    zustandT               zustand, zustandNext;
    logic [AW-1:0]         pc, pcNext;
    logic [WORDSIZE-1:0]   befehl, befehlNext;
    logic [AW-1:0]         befehlsZaehler, befehlsZaehlerNext;
    logic                  befehlGueltig, befehlGueltigNext;

    // The read strobe is combinational so a late grant from the arbiter still
    // launches the read in the same cycle. The RAM answers exactly one cycle
    // later, which is the WARTEN cycle.
    always_comb begin
        LesenAn        = (zustand == HOLEN) && SpeicherFrei;
        Holt           = (zustand == HOLEN) || (zustand == WARTEN);
        Adresse        = pc;
        Befehl         = befehl;
        BefehlsZaehler = befehlsZaehler;
        BefehlGueltig  = befehlGueltig;
    end

    // Next-state logic. A redirect wins over every ordinary transition except
    // in START. In VOLL the held instruction is still handed over when decode
    // is ready in the redirect cycle; dropping valid afterwards is correct in
    // either case. In WARTEN the arriving response is simply not captured,
    // and a stale response landing in the following HOLEN cycle is ignored
    // because DatenBereit is only looked at in WARTEN.
    always_comb begin
        zustandNext        = zustand;
        pcNext             = pc;
        befehlNext         = befehl;
        befehlsZaehlerNext = befehlsZaehler;
        befehlGueltigNext  = befehlGueltig;

        if (zustand == START) begin
            zustandNext = HOLEN;
        end else if (SprungAn) begin
            zustandNext       = HOLEN;
            pcNext            = SprungZiel;
            befehlGueltigNext = 1'b0;
        end else begin
            case (zustand)
                HOLEN: begin
                    if (SpeicherFrei) begin
                        zustandNext = WARTEN;
                    end
                end
                WARTEN: begin
                    if (DatenBereit) begin
                        zustandNext        = VOLL;
                        befehlNext         = DatenRaus;
                        befehlsZaehlerNext = pc;
                        befehlGueltigNext  = 1'b1;
                    end
                end
                VOLL: begin
                    // PC wraps naturally at 2^AW.
                    if (BefehlBereit) begin
                        zustandNext       = HOLEN;
                        pcNext            = pc + AW'(1);
                        befehlGueltigNext = 1'b0;
                    end
                end
                default: begin
                    zustandNext = START;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset; reset overrides any
    // request or response in progress.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            zustand        <= START;
            pc             <= AW'(START_ADRESSE);
            befehl         <= '0;
            befehlsZaehler <= '0;
            befehlGueltig  <= 1'b0;
        end else begin
            zustand        <= zustandNext;
            pc             <= pcNext;
            befehl         <= befehlNext;
            befehlsZaehler <= befehlsZaehlerNext;
            befehlGueltig  <= befehlGueltigNext;
        end
    end

endmodule

// File: tb/tb_befehl_holen.sv
// ---------------------------------------------------------------------------
// tb_befehl_holen - self-checking bench for befehl_holen
//
// A behavioural 1-cycle-latency RAM answers the fetch stage. A table of
// per-cycle vectors covers reset, the first fetches and a decode stall; the
// redirect, grant-stall, PC wrap and mid-request reset cases follow as
// hand-written cycle sequences.
// ---------------------------------------------------------------------------
module tb_befehl_holen;

    localparam int WS = 32;
    localparam int AW = 5;

    logic          Clock;
    logic          Reset_n;
    logic          SpeicherFrei;
    logic          LesenAn;
    logic [AW-1:0] Adresse;
    logic [WS-1:0] DatenRaus;
    logic          DatenBereit;
    logic          Holt;
    logic [WS-1:0] Befehl;
    logic [AW-1:0] BefehlsZaehler;
    logic          BefehlGueltig;
    logic          BefehlBereit;
    logic          SprungAn;
    logic [AW-1:0] SprungZiel;

    logic [WS-1:0] mem [32];

    int vectorCount = 0;
    int missCount   = 0;

    befehl_holen #(
        .WORDSIZE(32),
        .WORDS(32),
        .START_ADRESSE(0)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .SpeicherFrei(SpeicherFrei),
        .LesenAn(LesenAn),
        .Adresse(Adresse),
        .DatenRaus(DatenRaus),
        .DatenBereit(DatenBereit),
        .Holt(Holt),
        .Befehl(Befehl),
        .BefehlsZaehler(BefehlsZaehler),
        .BefehlGueltig(BefehlGueltig),
        .BefehlBereit(BefehlBereit),
        .SprungAn(SprungAn),
        .SprungZiel(SprungZiel)
    );

    // Free-running clock, period 10.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // RAM model: a read sampled at an edge returns data and a done pulse in
    // the following cycle.
    initial begin
        DatenBereit = 1'b0;
        DatenRaus   = '0;
    end

    always @(posedge Clock) begin
        DatenBereit <= LesenAn;
        if (LesenAn) begin
            DatenRaus <= mem[Adresse];
        end
    end

    typedef struct {
        logic          resetN;
        logic          frei;
        logic          bereit;
        logic          expLesen;
        logic          expHolt;
        logic          expGueltig;
        logic [WS-1:0] expBefehl;
        logic [AW-1:0] expZaehler;
        logic [AW-1:0] expAdresse;
    } vectorT;

    vectorT vecs [14];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WS-1:0] actual,
                               input logic [WS-1:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vectorT v);
        Reset_n      = v.resetN;
        SpeicherFrei = v.frei;
        BefehlBereit = v.bereit;
        SprungAn     = 1'b0;
        SprungZiel   = '0;
    endtask

    task automatic checkVector(input int idx, input vectorT v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".LesenAn"}, WS'(LesenAn), WS'(v.expLesen));
        checkOutput({tag, ".Holt"}, WS'(Holt), WS'(v.expHolt));
        checkOutput({tag, ".BefehlGueltig"}, WS'(BefehlGueltig), WS'(v.expGueltig));
        checkOutput({tag, ".Befehl"}, Befehl, v.expBefehl);
        checkOutput({tag, ".BefehlsZaehler"}, WS'(BefehlsZaehler), WS'(v.expZaehler));
        checkOutput({tag, ".Adresse"}, WS'(Adresse), WS'(v.expAdresse));
    endtask

    initial begin
        // Gauss program words that matter, background pattern elsewhere.
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hA000_0000 | WS'(i);
        end
        mem[0] = 32'h8040_000F;
        mem[1] = 32'h0020_0000;
        mem[4] = 32'h0020_1000;
        mem[9] = 32'h43FF_FFFF;

        // rstN frei bereit | lesen holt gueltig befehl bz adr
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 5'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 5'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 5'd0, 5'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 5'd0, 5'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8040_000F, 5'd0, 5'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8040_000F, 5'd0, 5'd1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8040_000F, 5'd0, 5'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 5'd1, 5'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0020_0000, 5'd1, 5'd2};

        Reset_n      = 1'b0;
        SpeicherFrei = 1'b1;
        BefehlBereit = 1'b1;
        SprungAn     = 1'b0;
        SprungZiel   = '0;
        tick();
        tick();

        // Reset, first two fetches, 5-cycle decode stall, release.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
            tick();
        end

        // Redirect to 4 while waiting on word 2.
        SprungAn = 1'b1; SprungZiel = 5'd4; #1;
        checkOutput("j4.wartenHolt", WS'(Holt), 32'd1);
        checkOutput("j4.wartenLesen", WS'(LesenAn), 32'd0);
        checkOutput("j4.wartenAdresse", WS'(Adresse), 32'd2);
        tick();
        SprungAn = 1'b0; #1;
        checkOutput("j4.holenAdresse", WS'(Adresse), 32'd4);
        checkOutput("j4.holenLesen", WS'(LesenAn), 32'd1);
        checkOutput("j4.holenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("j4.wartenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("j4.gueltig", WS'(BefehlGueltig), 32'd1);
        checkOutput("j4.zaehler", WS'(BefehlsZaehler), 32'd4);
        checkOutput("j4.befehl", Befehl, 32'h0020_1000);

        // Redirect to 8 while handing over word 4, then to 9 during the read of 8.
        SprungAn = 1'b1; SprungZiel = 5'd8; #1;
        checkOutput("j8.gueltigHeld", WS'(BefehlGueltig), 32'd1);
        tick();
        SprungAn = 1'b1; SprungZiel = 5'd9; #1;
        checkOutput("j9.lesen8", WS'(LesenAn), 32'd1);
        checkOutput("j9.adresse8", WS'(Adresse), 32'd8);
        tick();
        SprungAn = 1'b0; #1;
        checkOutput("j9.staleIgnoredLesen", WS'(LesenAn), 32'd1);
        checkOutput("j9.adresse9", WS'(Adresse), 32'd9);
        checkOutput("j9.staleGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("j9.wartenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("j9.gueltig", WS'(BefehlGueltig), 32'd1);
        checkOutput("j9.zaehler", WS'(BefehlsZaehler), 32'd9);
        checkOutput("j9.befehl", Befehl, 32'h43FF_FFFF);

        // Jump to 31, withhold the grant for 3 cycles, then check the wrap.
        SprungAn = 1'b1; SprungZiel = 5'd31; #1;
        tick();
        SprungAn = 1'b0; SpeicherFrei = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("stall%0d.Lesen", k), WS'(LesenAn), 32'd0);
            checkOutput($sformatf("stall%0d.Holt", k), WS'(Holt), 32'd1);
            checkOutput($sformatf("stall%0d.Gueltig", k), WS'(BefehlGueltig), 32'd0);
            checkOutput($sformatf("stall%0d.Adresse", k), WS'(Adresse), 32'd31);
            tick();
        end
        SpeicherFrei = 1'b1; #1;
        checkOutput("grant.Lesen", WS'(LesenAn), 32'd1);
        tick();
        #1;
        checkOutput("grant.wartenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("grant.gueltig", WS'(BefehlGueltig), 32'd1);
        checkOutput("grant.zaehler", WS'(BefehlsZaehler), 32'd31);
        checkOutput("grant.befehl", Befehl, 32'hA000_001F);
        tick();
        #1;
        checkOutput("wrap.adresse", WS'(Adresse), 32'd0);
        checkOutput("wrap.lesen", WS'(LesenAn), 32'd1);
        tick();
        #1;
        tick();
        #1;
        checkOutput("wrap.befehl", Befehl, 32'h8040_000F);
        tick();
        #1;
        checkOutput("pre.adresse1", WS'(Adresse), 32'd1);
        tick();

        // Reset while waiting on word 1.
        Reset_n = 1'b0; #1;
        checkOutput("rst.wartenHolt", WS'(Holt), 32'd1);
        tick();
        Reset_n = 1'b1; #1;
        checkOutput("rst.lesen", WS'(LesenAn), 32'd0);
        checkOutput("rst.holt", WS'(Holt), 32'd0);
        checkOutput("rst.gueltig", WS'(BefehlGueltig), 32'd0);
        checkOutput("rst.befehl", Befehl, 32'h0);
        checkOutput("rst.zaehler", WS'(BefehlsZaehler), 32'd0);
        checkOutput("rst.adresse", WS'(Adresse), 32'd0);
        tick();
        #1;
        checkOutput("rst.holenAdresse", WS'(Adresse), 32'd0);
        checkOutput("rst.holenLesen", WS'(LesenAn), 32'd1);
        checkOutput("rst.holenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("rst.wartenGueltig", WS'(BefehlGueltig), 32'd0);
        tick();
        #1;
        checkOutput("rst.gueltig2", WS'(BefehlGueltig), 32'd1);
        checkOutput("rst.befehl2", Befehl, 32'h8040_000F);
        checkOutput("rst.zaehler2", WS'(BefehlsZaehler), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
